cpu_encode: RTL
===============

// Module: cpu_encode
// PURPOSE
//   Streaming RV32I instruction encoder: inverse of cpu_decode. Packs op/rd/rs1/rs2/func/imm fields
//   into a 32-bit instruction word, tagged with a sequential byte address, so test harnesses and
//   loaders can emit program images. valid/ready on both sides, 1-cycle latency, 2-entry output buffer.
// PARAMETERS
//   ADDR_WIDTH  32  width of o_addr
//   BASE_ADDR   0   address given to first instruction accepted after reset
// PORTS
//   i_clk    in   1           clock
//   i_rst    in   1           reset
//   i_valid  in   1           input fields valid
//   o_ready  out  1           encoder can accept fields
//   i_op     in   7           opcode
//   i_rd     in   5           destination register
//   i_rs1    in   5           source register 1
//   i_rs2    in   5           source register 2
//   i_func   in   10          {funct7, funct3}
//   i_imm    in   32          immediate, same value/scaling cpu_decode produces
//   o_valid  out  1           output word valid
//   i_ready  in   1           consumer accepts output
//   o_inst   out  32          encoded instruction
//   o_addr   out  ADDR_WIDTH  byte address of o_inst
//   o_err    out  1           o_inst is unencodable (see CONFIGURATION)
// BEHAVIOUR
//   - One clock; reset is synchronous and active-high. Ports are i_clk and i_rst.
//   - Reset: o_valid=0, o_inst=0, o_addr=BASE_ADDR, o_err=0, buffer emptied, address counter=BASE_ADDR.
//     Reset mid-stream discards all buffered words.
//   - o_ready = !i_rst && skid entry empty. Input accepted when i_valid&&o_ready; output consumed when
//     o_valid&&i_ready. Producer holds fields stable until accepted.
//   - Storage: output register + one skid entry. Accepted word enters the output register if it is empty
//     or being consumed this cycle, else the skid. On consume with skid full, skid moves to the output register.
//     o_ready drops the cycle after the skid fills. Order strictly preserved; no loss or duplication.
//   - Latency: accept in cycle N -> o_valid in N+1 when not stalled. Throughput 1/cycle when i_ready=1.
//   - Address: each accepted word gets the counter value; counter += 4 per accept, wraps mod 2^ADDR_WIDTH.
//   - Format by i_op (F3=i_func[2:0], F7=i_func[9:3]):
//     R 0110011: {F7, rs2, rs1, F3, rd, op}; imm ignored
//     I 1100111/0000011/0010011/0001111/1110011: {imm[11:0], rs1, F3, rd, op}
//     S 0100011: {imm[11:5], rs2, rs1, F3, imm[4:0], op}
//     B 1100011: {imm[12], imm[10:5], rs2, rs1, F3, imm[4:1], imm[11], op}
//     U 0110111/0010111: {imm[19:0], rd, op}; imm is the unshifted 20-bit field
//     J 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}
//     Other opcode: o_inst=0.
//   - Fields not used by a format are ignored. Round trip: cpu_decode(o_inst) returns the input fields.
// CONFIGURATION
//   CPU_ENCODE_RANGE_CHECK_EN defined: o_err=1 on any of: unlisted opcode; I/S imm not sign-ext of imm[11:0];
//     B imm not sign-ext of imm[12:0] or imm[0]=1; U imm not sign-ext of imm[19:0];
//     J imm not sign-ext of imm[20:0] or imm[0]=1. o_err travels with its word.
//     The word is still emitted, with imm truncated as above.
//   Not defined: o_err tied 0; imm truncated silently; unlisted opcode still gives o_inst=0.
// TESTING
//   1. ADDI x1,x0,5 (op 0010011, rd 1, func 0, imm 5) -> next cycle o_inst=0x00500093, o_addr=0.
//   2. ADD x3,x1,x2 func 0 -> 0x002081B3; then SUB func 10'h100 -> 0x402081B3, o_addr=4.
//   3. BEQ x1,x2,imm 0xFFFFFFFC -> 0xFE208EE3. JAL x1,imm 0x800 -> 0x001000EF.
//   4. i_ready=0, 3 back-to-back inputs -> 2 accepted, o_ready=0, 3rd held. Release i_ready ->
//      addrs 0,4,8 in order. Reset mid-stream -> o_valid=0, next word at BASE_ADDR.
//   5. ADDR_WIDTH=4, 5 accepts -> addrs 0,4,8,12,0.
//   6. With macro: ADDI imm 2048 -> o_err=1; BEQ imm 3 -> o_err=1; op 7'h7F -> o_err=1, o_inst=0.
//      Without macro: same stimulus gives o_err=0.

Source files
------------

// File: rtl/cpu_encode.sv
// cpu_encode: streaming RV32I field-to-instruction encoder, 1-cycle latency, 2-entry output buffer.
// Define CPU_ENCODE_RANGE_CHECK_EN to flag unencodable opcodes/immediates on o_err.
module cpu_encode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [6:0]            i_op,
    input  logic [4:0]            i_rd,
    input  logic [4:0]            i_rs1,
    input  logic [4:0]            i_rs2,
    input  logic [9:0]            i_func,
    input  logic [31:0]           i_imm,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [31:0]           o_inst,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_err
);

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_X
    } fmt_e;

    fmt_e        fmt;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] enc_inst;
    logic        enc_err;

    assign f3 = i_func[2:0];
    assign f7 = i_func[9:3];

    always_comb begin
        fmt = FMT_X;
        case (i_op)
            7'b0110011: fmt = FMT_R;
            7'b1100111,
            7'b0000011,
            7'b0010011,
            7'b0001111,
            7'b1110011: fmt = FMT_I;
            7'b0100011: fmt = FMT_S;
            7'b1100011: fmt = FMT_B;
            7'b0110111,
            7'b0010111: fmt = FMT_U;
            7'b1101111: fmt = FMT_J;
            default:    fmt = FMT_X;
        endcase
    end

    always_comb begin
        enc_inst = '0;
        unique case (fmt)
            FMT_R: enc_inst = {f7, i_rs2, i_rs1, f3, i_rd, i_op};
            FMT_I: enc_inst = {i_imm[11:0], i_rs1, f3, i_rd, i_op};
            FMT_S: enc_inst = {i_imm[11:5], i_rs2, i_rs1, f3,
                               i_imm[4:0], i_op};
            FMT_B: enc_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1,
                               f3, i_imm[4:1], i_imm[11], i_op};
            FMT_U: enc_inst = {i_imm[19:0], i_rd, i_op};
            FMT_J: enc_inst = {i_imm[20], i_imm[10:1], i_imm[11],
                               i_imm[19:12], i_rd, i_op};
            default: enc_inst = '0;
        endcase
    end

`ifdef CPU_ENCODE_RANGE_CHECK_EN
    // Immediate fits when every bit above the field top equals the field sign bit.
    logic sx12;
    logic sx13;
    logic sx20;
    logic sx21;

    assign sx12 = (i_imm[31:11] == {21{i_imm[11]}});
    assign sx13 = (i_imm[31:12] == {20{i_imm[12]}});
    assign sx20 = (i_imm[31:19] == {13{i_imm[19]}});
    assign sx21 = (i_imm[31:20] == {12{i_imm[20]}});

    always_comb begin
        enc_err = 1'b0;
        unique case (fmt)
            FMT_R:   enc_err = 1'b0;
            FMT_I:   enc_err = !sx12;
            FMT_S:   enc_err = !sx12;
            FMT_B:   enc_err = !sx13 || i_imm[0];
            FMT_U:   enc_err = !sx20;
            FMT_J:   enc_err = !sx21 || i_imm[0];
            default: enc_err = 1'b1;
        endcase
    end
`else
    logic unused_imm;

    assign enc_err    = 1'b0;
    assign unused_imm = ^i_imm[31:21];
`endif

    logic                  out_v_q;
    logic                  out_v_d;
    logic [31:0]           out_inst_q;
    logic [31:0]           out_inst_d;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic [ADDR_WIDTH-1:0] out_addr_d;
    logic                  out_err_q;
    logic                  out_err_d;
    logic                  sk_v_q;
    logic                  sk_v_d;
    logic [31:0]           sk_inst_q;
    logic [31:0]           sk_inst_d;
    logic [ADDR_WIDTH-1:0] sk_addr_q;
    logic [ADDR_WIDTH-1:0] sk_addr_d;
    logic                  sk_err_q;
    logic                  sk_err_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic                  acc;
    logic                  cons;

    assign o_ready = !i_rst && !sk_v_q;
    assign acc     = i_valid && o_ready;
    assign cons    = out_v_q && i_ready;

    always_comb begin
        out_v_d    = out_v_q;
        out_inst_d = out_inst_q;
        out_addr_d = out_addr_q;
        out_err_d  = out_err_q;
        sk_v_d     = sk_v_q;
        sk_inst_d  = sk_inst_q;
        sk_addr_d  = sk_addr_q;
        sk_err_d   = sk_err_q;
        addr_d     = addr_q;
        if (acc) begin
            addr_d = addr_q + ADDR_WIDTH'(32'd4);
        end
        // A full skid blocks acceptance, so it only ever drains.
        if (sk_v_q) begin
            if (cons) begin
                out_inst_d = sk_inst_q;
                out_addr_d = sk_addr_q;
                out_err_d  = sk_err_q;
                sk_v_d     = 1'b0;
            end
        end else if (acc) begin
            if (!out_v_q || cons) begin
                out_v_d    = 1'b1;
                out_inst_d = enc_inst;
                out_addr_d = addr_q;
                out_err_d  = enc_err;
            end else begin
                sk_v_d    = 1'b1;
                sk_inst_d = enc_inst;
                sk_addr_d = addr_q;
                sk_err_d  = enc_err;
            end
        end else if (cons) begin
            out_v_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_v_q    <= 1'b0;
            out_inst_q <= '0;
            out_addr_q <= BASE_ADDR;
            out_err_q  <= 1'b0;
            sk_v_q     <= 1'b0;
            sk_inst_q  <= '0;
            sk_addr_q  <= BASE_ADDR;
            sk_err_q   <= 1'b0;
            addr_q     <= BASE_ADDR;
        end else begin
            out_v_q    <= out_v_d;
            out_inst_q <= out_inst_d;
            out_addr_q <= out_addr_d;
            out_err_q  <= out_err_d;
            sk_v_q     <= sk_v_d;
            sk_inst_q  <= sk_inst_d;
            sk_addr_q  <= sk_addr_d;
            sk_err_q   <= sk_err_d;
            addr_q     <= addr_d;
        end
    end

    assign o_valid = out_v_q;
    assign o_inst  = out_inst_q;
    assign o_addr  = out_addr_q;
    assign o_err   = out_err_q;

endmodule
